// File: rtl/pipelined_cla_adder.sv
// ============================================================================
// Module   : pipelined_cla_adder
// Purpose  : Carry-lookahead-group adder split into valid/ready pipeline stages.
//            Operand bits ride along, skewed, until their stage sums them.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipelined_cla_adder #(
  parameter int ADDER_WIDTH    = 48,
  parameter int CLA_GRP_WIDTH  = 12,
  parameter int GRPS_PER_STAGE = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ADDER_WIDTH-1:0] in1,
  input  logic [ADDER_WIDTH-1:0] in2,
  input  logic                   effectiveOp,
  input  logic                   sticky,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ADDER_WIDTH-1:0] sum,
  output logic                   cout,
  output logic                   sticky_out,
  output logic                   sum_zero
);

  localparam int NUM_GRP = ADDER_WIDTH / CLA_GRP_WIDTH;
  localparam int STAGES  = (NUM_GRP + GRPS_PER_STAGE - 1) / GRPS_PER_STAGE;

  generate
    if ((ADDER_WIDTH % CLA_GRP_WIDTH) != 0) begin : g_width_check
      $error("ADDER_WIDTH must be a multiple of CLA_GRP_WIDTH");
    end
  endgenerate

  // Stage inputs (index 0 = ports, index k = output registers of stage k-1)
  logic [ADDER_WIDTH-1:0] a_x [STAGES];
  logic [ADDER_WIDTH-1:0] b_x [STAGES];
  logic [ADDER_WIDTH-1:0] s_x [STAGES];
  logic [STAGES-1:0]      c_x;

  logic [ADDER_WIDTH-1:0] a_d [STAGES];
  logic [ADDER_WIDTH-1:0] b_d [STAGES];
  logic [ADDER_WIDTH-1:0] s_d [STAGES];
  logic [ADDER_WIDTH-1:0] a_q [STAGES];
  logic [ADDER_WIDTH-1:0] b_q [STAGES];
  logic [ADDER_WIDTH-1:0] s_q [STAGES];
  logic [STAGES-1:0]      c_d, c_q;
  logic [STAGES-1:0]      v_d, v_q;
  logic [STAGES-1:0]      t_d, t_q;
  logic                   stall;

  assign c_x = STAGES'({c_q, effectiveOp});
  assign v_d = STAGES'({v_q, in_valid});
  assign t_d = STAGES'({t_q, sticky});

  always_comb begin
    a_x[0] = in1;
    b_x[0] = in2;
    s_x[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      a_x[k] = a_q[k-1];
      b_x[k] = b_q[k-1];
      s_x[k] = s_q[k-1];
    end
  end

  // Each stage sums its own groups; the carry chains straight through them.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      a_d[k] = a_x[k];
      b_d[k] = b_x[k];
      s_d[k] = s_x[k];
      c_d[k] = c_x[k];
      for (int g = 0; g < NUM_GRP; g++) begin
        if ((g / GRPS_PER_STAGE) == k) begin
          for (int j = 0; j < CLA_GRP_WIDTH; j++) begin
            s_d[k][g*CLA_GRP_WIDTH+j] = a_x[k][g*CLA_GRP_WIDTH+j]
                                      ^ b_x[k][g*CLA_GRP_WIDTH+j] ^ c_d[k];
            c_d[k] = (a_x[k][g*CLA_GRP_WIDTH+j] & b_x[k][g*CLA_GRP_WIDTH+j])
                   | (c_d[k] & (a_x[k][g*CLA_GRP_WIDTH+j] | b_x[k][g*CLA_GRP_WIDTH+j]));
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
      c_q <= '0;
      v_q <= '0;
      t_q <= '0;
    end else if (!stall) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
      end
      c_q <= c_d;
      v_q <= v_d;
      t_q <= t_d;
    end
  end

  assign out_valid  = v_q[STAGES-1];
  assign stall      = out_valid & ~out_ready;
  assign in_ready   = ~stall;
  assign sum        = s_q[STAGES-1];
  assign cout       = c_q[STAGES-1];
  assign sticky_out = t_q[STAGES-1];
  assign sum_zero   = out_valid & (s_q[STAGES-1] == '0);

endmodule

`default_nettype wire

// File: tb/tb_pipelined_cla_adder.sv
// ============================================================================
// Module   : tb_pipelined_cla_adder
// Purpose  : Scoreboard bench for pipelined_cla_adder at default parameters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipelined_cla_adder;

  localparam int W      = 48;
  localparam int STAGES = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in1;
  logic [W-1:0] in2;
  logic         effectiveOp;
  logic         sticky;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         sticky_out;
  logic         sum_zero;

  pipelined_cla_adder #(
    .ADDER_WIDTH   (W),
    .CLA_GRP_WIDTH (12),
    .GRPS_PER_STAGE(2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in1        (in1),
    .in2        (in2),
    .effectiveOp(effectiveOp),
    .sticky     (sticky),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sum        (sum),
    .cout       (cout),
    .sticky_out (sticky_out),
    .sum_zero   (sum_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         st;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int   tests   = 0;
  int   fails   = 0;
  int   cyc     = 0;
  int   outs    = 0;
  bit   chk_lat = 1'b1;
  bit   accepted;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one cycle of inputs; scores the output transfer and records the
  // input transfer that the coming rising edge will perform.
  task automatic cycle(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic op, input logic st, input logic ordy);
    logic [W:0] full;
    exp_t       e;
    in_valid    = v;
    in1         = a;
    in2         = b;
    effectiveOp = op;
    sticky      = st;
    out_ready   = ordy;
    #1;
    if (out_valid && out_ready) begin
      check("result_expected", 64'(sb.size() != 0), 64'(1));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("sum", 64'(sum), 64'(e.sum));
        check("cout", 64'(cout), 64'(e.cout));
        check("sticky_out", 64'(sticky_out), 64'(e.st));
        check("sum_zero", 64'(sum_zero), 64'(e.sum == '0));
        if (chk_lat) check("latency", 64'(cyc - e.cyc), 64'(STAGES));
        outs++;
      end
    end
    accepted = in_valid && in_ready;
    if (accepted) begin
      full  = {1'b0, a} + {1'b0, b} + (W+1)'(op);
      e.sum = full[W-1:0];
      e.cout = full[W];
      e.st  = st;
      e.cyc = cyc;
      sb.push_back(e);
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 10) begin
      cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      n++;
    end
    check("drain_empty", 64'(sb.size()), 64'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] r;
    rst_n = 1'b0; in_valid = 1'b0; in1 = '0; in2 = '0;
    effectiveOp = 1'b0; sticky = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_sum", 64'(sum), 64'(0));
    check("rst_cout", 64'(cout), 64'(0));
    check("rst_sticky_out", 64'(sticky_out), 64'(0));
    check("rst_sum_zero", 64'(sum_zero), 64'(0));
    rst_n = 1'b1;

    // First edge after reset release must accept; then the directed vectors.
    cycle(1'b1, 48'h0000_0000_0FFF, 48'h1, 1'b0, 1'b0, 1'b1);
    check("first_accept", 64'(accepted), 64'(1));
    drain();
    cycle(1'b1, 48'hFFFF_FFFF_FFFF, 48'h0, 1'b1, 1'b0, 1'b1);
    drain();
    cycle(1'b1, 48'h0000_0000_0005, 48'hFFFF_FFFF_FFFC, 1'b1, 1'b1, 1'b1);
    drain();
    r = W'({$urandom(), $urandom()});
    cycle(1'b1, r, ~r, 1'b1, 1'b0, 1'b1);
    drain();

    // Back-to-back random stream
    outs = 0;
    for (int i = 0; i < 10; i++) begin
      r = W'({$urandom(), $urandom()});
      cycle(1'b1, r, W'({$urandom(), $urandom()}), 1'(i % 2), 1'($urandom_range(1)), 1'b1);
    end
    drain();
    check("b2b_count", 64'(outs), 64'(10));

    // Backpressure with a full pipeline
    chk_lat = 1'b0;
    outs = 0;
    cycle(1'b1, 48'h1234_5678_9ABC, 48'h1111_1111_1111, 1'b0, 1'b1, 1'b1);
    cycle(1'b1, 48'h8000_0000_0000, 48'h8000_0000_0001, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 48'h0000_0FFF_F000, 48'h0000_0000_1000, 1'b0, 1'b1, 1'b0);
      check("stall_in_ready", 64'(in_ready), 64'(0));
      check("stall_out_valid", 64'(out_valid), 64'(1));
      check("stall_sum_hold", 64'(sum), 64'(sb[0].sum));
      check("stall_cout_hold", 64'(cout), 64'(sb[0].cout));
    end
    begin
      int n = 0;
      accepted = 1'b0;
      while (!accepted && n < 5) begin
        cycle(1'b1, 48'h0000_0FFF_F000, 48'h0000_0000_1000, 1'b0, 1'b1, 1'b1);
        n++;
      end
      check("release_accept", 64'(accepted), 64'(1));
    end
    drain();
    check("stall_count", 64'(outs), 64'(3));
    chk_lat = 1'b1;

    // Reset with two operations in flight
    outs = 0;
    cycle(1'b1, 48'h0000_0000_0001, 48'h0000_0000_0002, 1'b0, 1'b1, 1'b1);
    cycle(1'b1, 48'h0000_0000_0003, 48'h0000_0000_0004, 1'b0, 1'b0, 1'b1);
    check("pre_reset_valid", 64'(out_valid), 64'(1));
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    check("async_rst_valid", 64'(out_valid), 64'(0));
    check("async_rst_sum", 64'(sum), 64'(0));
    check("async_rst_ready", 64'(in_ready), 64'(1));
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      check("no_ghost", 64'(out_valid), 64'(0));
    end
    check("ghost_count", 64'(outs), 64'(0));
    cycle(1'b1, 48'h0000_00FF_FFFF, 48'h0000_0000_0001, 1'b0, 1'b1, 1'b1);
    check("post_rst_accept", 64'(accepted), 64'(1));
    drain();
    check("post_rst_count", 64'(outs), 64'(1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
